fir_alu: RTL and testbench

// - 64-tap, 16-bit signed FIR filter datapath with one time-shared MAC.
// - After reset it loads 64 coefficients serially. It then consumes one input sample

---
 rtl/fir_alu.sv | 112 +++++++++++
 tb/tb_fir_alu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fir_alu.sv
// 64-tap Q1.15 FIR datapath with a single time-shared MAC: serial coefficient load after
// reset, then one input sample and one saturated output sample per TAPS-clock frame.
module fir_alu #(
   parameter int TAPS = 64,
   parameter int DW   = 16,
   parameter int ACCW = 38,
   parameter int FRAC = 15
) (
   input  logic          clk2,
   input  logic          ALU_restn,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] b,
   input  logic          b_valid,
   output logic [DW-1:0] y
);

   localparam int CW = $clog2(TAPS);
   localparam logic signed [ACCW-1:0] P_MAX = ACCW'((64'd1 << (DW-1)) - 64'd1);
   localparam logic signed [ACCW-1:0] P_MIN = ~P_MAX;

   typedef enum logic [1:0] {S_LOAD, S_IDLE, S_MAC} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [CW-1:0]          r_cnt;
   logic signed [DW-1:0]   r_coef [TAPS];
   logic signed [DW-1:0]   r_dly  [TAPS];
   logic signed [ACCW-1:0] r_acc;
   logic [DW-1:0]          r_y;

   logic                   w_last;
   logic                   w_start;
   logic signed [DW-1:0]   w_tap;
   logic signed [2*DW-1:0] w_prod;
   logic signed [ACCW-1:0] w_sum;
   logic signed [ACCW-1:0] w_shift;
   logic [DW-1:0]          w_sat;

   assign w_last  = (r_cnt == CW'(TAPS-1));
   assign w_start = (r_state == S_IDLE) && b_valid;

   // Cycle 0 of a frame multiplies the incoming x directly, since d[0] is written on that same edge.
   assign w_tap   = (r_state == S_IDLE) ? $signed(x) : r_dly[r_cnt];
   assign w_prod  = w_tap * r_coef[r_cnt];
   assign w_sum   = ((r_state == S_IDLE) ? '0 : r_acc)
                  + {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
   assign w_shift = w_sum >>> FRAC;

   always_comb begin
      w_sat = w_shift[DW-1:0];
      if (w_shift > P_MAX)
         w_sat = {1'b0, {(DW-1){1'b1}}};
      else if (w_shift < P_MIN)
         w_sat = {1'b1, {(DW-1){1'b0}}};
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD:  if (w_last)  w_next = S_IDLE;
         S_IDLE:  if (b_valid) w_next = S_MAC;
         S_MAC:   if (w_last)  w_next = S_IDLE;
         default: w_next = S_LOAD;
      endcase
   end

   always_ff @(posedge clk2 or negedge ALU_restn) begin
      if (!ALU_restn)
         r_state <= S_LOAD;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk2 or negedge ALU_restn) begin
      if (!ALU_restn) begin
         r_cnt <= '0;
         r_acc <= '0;
         r_y   <= '0;
         for (int unsigned i = 0; i < TAPS; i++)
            r_dly[i] <= '0;
      end else begin
         case (r_state)
            S_LOAD: r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            S_IDLE: begin
               if (w_start) begin
                  r_dly[0] <= $signed(x);
                  for (int unsigned i = 1; i < TAPS; i++)
                     r_dly[i] <= r_dly[i-1];
                  r_acc <= w_sum;
                  r_cnt <= CW'(1);
               end
            end
            S_MAC: begin
               r_acc <= w_sum;
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last)
                  r_y <= w_sat;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Coefficient RAM has no reset; it is rewritten by the load phase after every reset.
   always_ff @(posedge clk2) begin
      if (r_state == S_LOAD)
         r_coef[r_cnt] <= $signed(b);
   end

   assign y = r_y;

endmodule

// File: tb/tb_fir_alu.sv
// Self-checking bench for fir_alu: directed phases with random data, compared against a
// convolution model kept as plain integer arrays.
module tb_fir_alu;

   logic        clk2 = 1'b0;
   logic        ALU_restn = 1'b1;
   logic [15:0] x = '0;
   logic [15:0] b = '0;
   logic        b_valid = 1'b0;
   logic [15:0] y;

   int checks   = 0;
   int failures = 0;

   longint m_coef [64];
   longint m_hist [64];

   fir_alu #(.TAPS(64), .DW(16), .ACCW(38), .FRAC(15)) dut (
      .clk2(clk2), .ALU_restn(ALU_restn), .x(x), .b(b), .b_valid(b_valid), .y(y)
   );

   always #5 clk2 = ~clk2;

   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: y=%h expected %h", tag, got, exp);
      end
   endtask

   // y[n] = sat16((sum_k b[k]*x[n-k]) >>> 15)
   function automatic logic [15:0] model_y();
      longint acc = 0;
      for (int k = 0; k < 64; k++)
         acc += m_coef[k] * m_hist[k];
      acc = acc >>> 15;
      if (acc > 32767)  return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
      return acc[15:0];
   endfunction

   task automatic model_push(input logic [15:0] xv);
      logic signed [15:0] s;
      s = xv;
      for (int i = 63; i > 0; i--)
         m_hist[i] = m_hist[i-1];
      m_hist[0] = s;
   endtask

   task automatic clear_hist();
      for (int i = 0; i < 64; i++)
         m_hist[i] = 0;
   endtask

   task automatic rand_coefs();
      logic signed [15:0] t;
      for (int k = 0; k < 64; k++) begin
         t = 16'($urandom);
         m_coef[k] = t;
      end
   endtask

   task automatic do_reset();
      #2 ALU_restn = 1'b0;
      #1 check("reset_async", y, 16'h0000);
      tick();
      tick();
      check("reset_hold", y, 16'h0000);
      ALU_restn = 1'b1;
      clear_hist();
   endtask

   // Drives the 64 load edges; bv lets b_valid be asserted during load to show it is ignored.
   task automatic load(input bit bv);
      logic [63:0] c;
      for (int k = 0; k < 64; k++) begin
         c = m_coef[k];
         b = c[15:0];
         b_valid = bv;
         x = 16'($urandom);
         tick();
         if (k % 16 == 15) check("load_y0", y, 16'h0000);
      end
   endtask

   // One full frame; drop_at >= 0 deasserts b_valid at that cycle of the frame.
   task automatic frame(input logic [15:0] xv, input int drop_at);
      logic [15:0] exp;
      logic [15:0] prev;
      x = xv;
      b_valid = 1'b1;
      model_push(xv);
      exp  = model_y();
      prev = y;
      tick();
      for (int c = 1; c < 64; c++) begin
         if (c == drop_at) b_valid = 1'b0;
         x = 16'($urandom);
         if (c == 32) check("frame_hold", y, prev);
         tick();
      end
      check("frame_y", y, exp);
   endtask

   task automatic idle(input int n);
      logic [15:0] held;
      held = y;
      b_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         x = 16'($urandom);
         tick();
         if (i % 20 == 19) check("idle_hold", y, held);
      end
   endtask

   initial begin
      // Reset and a 200-clock window with b_valid low
      clear_hist();
      rand_coefs();
      do_reset();
      load(1'b0);
      for (int i = 0; i < 136; i++) begin
         x = 16'($urandom);
         tick();
         if (i % 17 == 0) check("idle_after_load", y, 16'h0000);
      end

      // Impulse response; b_valid high during load must not disturb loading
      do_reset();
      for (int k = 0; k < 64; k++) m_coef[k] = 256 * (k + 1);
      load(1'b1);
      for (int n = 0; n <= 64; n++) begin
         frame((n == 0) ? 16'h4000 : 16'h0000, -1);
         check("impulse_const", y, (n < 64) ? 16'((n + 1) * 128) : 16'h0000);
      end
      b_valid = 1'b0;

      // Negative scale
      do_reset();
      for (int k = 0; k < 64; k++) m_coef[k] = 0;
      m_coef[0] = -32768;
      load(1'b0);
      frame(16'h1000, -1);
      check("neg_scale", y, 16'hF000);
      b_valid = 1'b0;

      // Saturation both ways
      do_reset();
      for (int k = 0; k < 64; k++) m_coef[k] = 32767;
      load(1'b0);
      for (int n = 0; n < 64; n++) frame(16'h7FFF, -1);
      check("sat_pos", y, 16'h7FFF);
      for (int n = 0; n < 64; n++) frame(16'h8000, -1);
      check("sat_neg", y, 16'h8000);
      b_valid = 1'b0;

      // Random coefficients and samples
      do_reset();
      rand_coefs();
      load(1'b0);
      for (int n = 0; n < 20; n++) frame(16'($urandom), -1);

      // Run gating: drop b_valid mid-frame, idle with changing x, then resume
      frame(16'($urandom), 20);
      idle(100);
      for (int n = 0; n < 5; n++) frame(16'($urandom), -1);

      // Mid-frame reset at frame counter 30
      x = 16'($urandom);
      b_valid = 1'b1;
      tick();
      for (int c = 1; c < 30; c++) tick();
      b_valid = 1'b0;
      do_reset();
      rand_coefs();
      load(1'b0);
      for (int n = 0; n < 8; n++) frame(16'($urandom), -1);
      b_valid = 1'b0;
      idle(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
